// File: rtl/fdc_pkg.sv
// Shared encodings for the fetch/decode/control sequencer: opcodes, ALU codes,
// FSM states and the NOP word the instruction register holds out of reset.
package fdc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [15:0] RESET_IR = 16'hE000;

  // Widen a 4-bit two's-complement field to a full data word.
  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of the instruction register into register
// addresses, ALU controls and instruction-class flags.
module instr_field_decode
  import fdc_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [3:0]  unused_pad_n,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [2:0]  alu_op,
  output logic        use_imm,
  output logic [15:0] imm,
  output logic        is_wb,
  output logic        is_beq,
  output logic        is_jmp,
  output logic        is_halt
);

  logic [3:0] op;

  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign rs  = ir[7:4];
  assign rt  = ir[3:0];
  assign imm = sext4(ir[3:0]);

  // Reserved opcodes fall into the default arm and behave as NOP.
  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    is_wb   = 1'b0;
    is_beq  = 1'b0;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
        alu_op = op[2:0];
        is_wb  = 1'b1;
      end
      OP_ADDI: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        is_wb   = 1'b1;
      end
      OP_BEQ:  is_beq  = 1'b1;
      OP_JMP:  is_jmp  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      OP_NOP:  ;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/control sequencer: owns PC, IR and the
// FETCH/DECODE/EXEC/WB/HALT state machine feeding the register file.
module fetch_decode_ctrl
  import fdc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ack,
  input  logic            rf_eq,
  output logic [3:0]      Rs,
  output logic [3:0]      Rt,
  output logic [3:0]      Rd,
  output logic [2:0]      alu_op,
  output logic            use_imm,
  output logic [15:0]     imm,
  output logic            wr,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_e          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [15:0]     ir;
  logic            run;
  logic            fetch_done;
  logic            is_wb, is_beq, is_jmp, is_halt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;

  instr_field_decode u_decode (
    .ir           (ir),
    .unused_pad_n (4'h0),
    .rd           (Rd),
    .rs           (Rs),
    .rt           (Rt),
    .alu_op       (alu_op),
    .use_imm      (use_imm),
    .imm          (imm),
    .is_wb        (is_wb),
    .is_beq       (is_beq),
    .is_jmp       (is_jmp),
    .is_halt      (is_halt)
  );

  // run holds the request off for the partial cycle in which reset releases.
  assign imem_req   = (state == ST_FETCH) && run;
  assign imem_addr  = pc;
  assign wr         = (state == ST_WB);
  assign halted     = (state == ST_HALT);
  assign fetch_done = imem_req && imem_ack;
  assign pc_inc     = pc + PC_W'(1);
  assign br_off     = {{(PC_W-4){ir[11]}}, ir[11:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= RESET_IR;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      run   <= 1'b1;
      if (fetch_done) ir <= imem_rdata;
    end
  end

  // Non-writeback instructions resolve the PC on the EXEC edge; writeback ones on the WB edge.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_FETCH:  if (fetch_done) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (is_halt) begin
          state_nxt = ST_HALT;
        end else if (is_wb) begin
          state_nxt = ST_WB;
        end else begin
          state_nxt = ST_FETCH;
          if (is_jmp)              pc_nxt = {pc[PC_W-1:12], ir[11:0]};
          else if (is_beq && rf_eq) pc_nxt = pc_inc + br_off;
          else                      pc_nxt = pc_inc;
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        pc_nxt    = pc_inc;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

endmodule
